// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the kanade32 pipeline stall/flush controller:
// FSM state encodings, the register-zero constant and counter saturation.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LU_HOLD = 2'd1,
        ST_DWAIT   = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CNT_MAX) ? CNT_MAX : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// Combinational load-use hazard detector: a load in DE whose destination
// is read by the instruction currently in FD.
import pipeline_ctrl_pkg::*;

module load_use_detect (
    input  logic [4:0] fd_rs,
    input  logic [4:0] fd_rt,
    input  logic       fd_uses_rs,
    input  logic       fd_uses_rt,
    input  logic       de_mem_read,
    input  logic [4:0] de_dst_reg,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = fd_uses_rs && (fd_rs == de_dst_reg);
    assign rt_match = fd_uses_rt && (fd_rt == de_dst_reg);
    // r0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign hazard   = de_mem_read && (de_dst_reg != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: load-use bubbles, imem/dmem wait handling,
// redirect squashing, dmem timeout halt and saturating perf counters.
import pipeline_ctrl_pkg::*;

module pipeline_ctrl #(
    parameter int WAIT_TIMEOUT     = 1024,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  fd_rs,
    input  logic [4:0]  fd_rt,
    input  logic        fd_uses_rs,
    input  logic        fd_uses_rt,
    input  logic        de_mem_read,
    input  logic [4:0]  de_dst_reg,
    input  logic        em_redirect,
    input  logic        em_mem_access,
    input  logic        dmem_ready,
    input  logic        imem_ready,
    output logic        pc_wren,
    output logic        fd_wren,
    output logic        de_wren,
    output logic        em_wren,
    output logic        mw_wren,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        em_flush,
    output logic        pc_redirect,
    output logic        halted,
    output logic        err_timeout,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    // The entry cycle is the first not-ready cycle, so the counter value seen
    // in DWAIT on the WAIT_TIMEOUT-th not-ready cycle is WAIT_TIMEOUT-2.
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 2);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        lu_resume;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    logic hazard;
    logic dmem_wait;
    logic in_hold;
    logic do_redirect;
    logic do_lu;

    load_use_detect u_load_use_detect (
        .fd_rs       (fd_rs),
        .fd_rt       (fd_rt),
        .fd_uses_rs  (fd_uses_rs),
        .fd_uses_rt  (fd_uses_rt),
        .de_mem_read (de_mem_read),
        .de_dst_reg  (de_dst_reg),
        .hazard      (hazard)
    );

    assign dmem_wait   = em_mem_access && !dmem_ready;
    assign in_hold     = (state == ST_LU_HOLD) || (state == ST_DWAIT && lu_resume);
    assign do_redirect = !reset && state != ST_ERROR && !dmem_wait && em_redirect;
    assign do_lu       = !reset && state != ST_ERROR && !dmem_wait && !em_redirect
                         && (hazard || in_hold);

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // if-chain can leave one unassigned and infer a latch.
        pc_wren     = 1'b0;
        fd_wren     = 1'b0;
        de_wren     = 1'b0;
        em_wren     = 1'b0;
        mw_wren     = 1'b0;
        fd_flush    = 1'b0;
        de_flush    = 1'b0;
        em_flush    = 1'b0;
        pc_redirect = 1'b0;
        halted      = 1'b0;
        err_timeout = 1'b0;
        if (reset) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
        end else if (state == ST_ERROR) begin
            halted      = 1'b1;
            err_timeout = 1'b1;
        end else if (!dmem_wait) begin
            pc_wren = 1'b1;
            fd_wren = 1'b1;
            de_wren = 1'b1;
            em_wren = 1'b1;
            mw_wren = 1'b1;
            if (do_redirect) begin
                pc_redirect = 1'b1;
                fd_flush    = 1'b1;
                de_flush    = 1'b1;
                em_flush    = 1'b1;
            end else if (do_lu) begin
                pc_wren  = 1'b0;
                fd_wren  = 1'b0;
                de_flush = 1'b1;
            end else if (!imem_ready) begin
                pc_wren  = 1'b0;
                fd_flush = 1'b1;
            end
        end
    end

    assign stall_count = reset ? 32'd0 : stall_cnt;
    assign flush_count = reset ? 32'd0 : flush_cnt;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            lu_resume <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state != ST_ERROR) begin
            if (!pc_wren) stall_cnt <= sat_inc(stall_cnt);
            if (do_redirect) flush_cnt <= sat_inc(flush_cnt);

            if (dmem_wait) begin
                if (state == ST_DWAIT) begin
                    if (wait_cnt == WAIT_LAST) state <= ST_ERROR;
                    else wait_cnt <= wait_cnt + 16'd1;
                end else begin
                    state     <= ST_DWAIT;
                    wait_cnt  <= '0;
                    lu_resume <= (state == ST_LU_HOLD);
                end
            end else begin
                lu_resume <= 1'b0;
                if (do_lu && hazard && !in_hold && LOAD_USE_BUBBLES == 2) state <= ST_LU_HOLD;
                else state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table-driven single-cycle vectors
// plus directed multi-cycle sequences (dmem wait, timeout, LU_HOLD, saturation).
module tb_pipeline_ctrl;

    // Output word order: {pc,fd,de,em,mw wren, fd,de,em flush, pc_redirect, halted, err_timeout}
    localparam logic [10:0] O_RUN = 11'b11111_000_0_00;
    localparam logic [10:0] O_LU  = 11'b00111_010_0_00;
    localparam logic [10:0] O_IW  = 11'b01111_100_0_00;
    localparam logic [10:0] O_RED = 11'b11111_111_1_00;
    localparam logic [10:0] O_FRZ = 11'b00000_000_0_00;
    localparam logic [10:0] O_ERR = 11'b00000_000_0_11;
    localparam logic [10:0] O_RST = 11'b00000_111_0_00;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  fd_rs, fd_rt, de_dst_reg;
    logic        fd_uses_rs, fd_uses_rt, de_mem_read;
    logic        em_redirect, em_mem_access, dmem_ready, imem_ready;

    logic        pc_wren, fd_wren, de_wren, em_wren, mw_wren;
    logic        fd_flush, de_flush, em_flush, pc_redirect, halted, err_timeout;
    logic [31:0] stall_count, flush_count;
    logic        pc_wren2, fd_wren2, de_wren2, em_wren2, mw_wren2;
    logic        fd_flush2, de_flush2, em_flush2, pc_redirect2, halted2, err_timeout2;
    logic [31:0] stall_count2, flush_count2;

    logic [10:0] obs, obs2;
    assign obs  = {pc_wren, fd_wren, de_wren, em_wren, mw_wren,
                   fd_flush, de_flush, em_flush, pc_redirect, halted, err_timeout};
    assign obs2 = {pc_wren2, fd_wren2, de_wren2, em_wren2, mw_wren2,
                   fd_flush2, de_flush2, em_flush2, pc_redirect2, halted2, err_timeout2};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.WAIT_TIMEOUT(4), .LOAD_USE_BUBBLES(1)) dut (
        .clk(clk), .reset(reset),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
        .de_mem_read(de_mem_read), .de_dst_reg(de_dst_reg),
        .em_redirect(em_redirect), .em_mem_access(em_mem_access),
        .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .pc_wren(pc_wren), .fd_wren(fd_wren), .de_wren(de_wren), .em_wren(em_wren),
        .mw_wren(mw_wren), .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
        .pc_redirect(pc_redirect), .halted(halted), .err_timeout(err_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_ctrl #(.WAIT_TIMEOUT(4), .LOAD_USE_BUBBLES(2)) dut2 (
        .clk(clk), .reset(reset),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
        .de_mem_read(de_mem_read), .de_dst_reg(de_dst_reg),
        .em_redirect(em_redirect), .em_mem_access(em_mem_access),
        .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .pc_wren(pc_wren2), .fd_wren(fd_wren2), .de_wren(de_wren2), .em_wren(em_wren2),
        .mw_wren(mw_wren2), .fd_flush(fd_flush2), .de_flush(de_flush2), .em_flush(em_flush2),
        .pc_redirect(pc_redirect2), .halted(halted2), .err_timeout(err_timeout2),
        .stall_count(stall_count2), .flush_count(flush_count2)
    );

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic        mrd;
        logic [4:0]  dst;
        logic        red;
        logic        macc;
        logic        drdy;
        logic        irdy;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic mrd, input logic [4:0] dst,
                         input logic red, input logic macc, input logic drdy, input logic irdy);
        fd_rs = rs; fd_rt = rt; fd_uses_rs = urs; fd_uses_rt = urt;
        de_mem_read = mrd; de_dst_reg = dst; em_redirect = red;
        em_mem_access = macc; dmem_ready = drdy; imem_ready = irdy;
    endtask

    // Advance to the next negedge, apply inputs, let outputs settle before the posedge.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic mrd, input logic [4:0] dst,
                        input logic red, input logic macc, input logic drdy, input logic irdy);
        @(negedge clk);
        drive(rs, rt, urs, urt, mrd, dst, red, macc, drdy, irdy);
        #1;
    endtask

    task automatic idle();
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic hazard_step();
        step(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic dwait_step();
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check("reset_outputs", 32'(obs), 32'(O_RST));
        check("reset_stall_count", stall_count, 32'd0);
        check("reset_flush_count", flush_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        //           rs    rt    urs   urt   mrd   dst   red   macc  drdy  irdy  expected
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_RUN};
        vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, O_LU};
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_RUN};
        vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_RUN};
        vecs[4]  = '{5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, O_LU};
        vecs[5]  = '{5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, O_RUN};
        vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_IW};
        vecs[7]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, O_RED};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, O_FRZ};
        vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, O_FRZ};
        vecs[10] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, O_LU};
        vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, O_RUN};

        reset = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        do_reset();

        // Single-cycle vectors against the one-bubble controller.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].mrd, vecs[i].dst,
                 vecs[i].red, vecs[i].macc, vecs[i].drdy, vecs[i].irdy);
            check($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
        end
        idle();
        check("table_stall_count", stall_count, 32'd6);
        check("table_flush_count", flush_count, 32'd1);

        // Three frozen cycles, then ready together with a redirect.
        for (int i = 0; i < 3; i++) begin
            dwait_step();
            check($sformatf("dwait3_freeze%0d", i), 32'(obs), 32'(O_FRZ));
        end
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("dwait3_redirect", 32'(obs), 32'(O_RED));
        idle();
        check("dwait3_stall_count", stall_count, 32'd9);
        check("dwait3_flush_count", flush_count, 32'd2);

        // Timeout: four not-ready cycles, then ERROR which ignores everything.
        for (int i = 0; i < 4; i++) begin
            dwait_step();
            check($sformatf("timeout_freeze%0d", i), 32'(obs), 32'(O_FRZ));
        end
        dwait_step();
        check("timeout_error", 32'(obs), 32'(O_ERR));
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("error_sticky", 32'(obs), 32'(O_ERR));
        check("error_stall_count", stall_count, 32'd13);
        check("error_flush_count", flush_count, 32'd2);
        do_reset();
        idle();
        check("post_reset_run", 32'(obs), 32'(O_RUN));
        check("post_reset_stall", stall_count, 32'd0);

        // Two-bubble load-use versus one-bubble.
        hazard_step();
        check("lu2_first", 32'(obs2), 32'(O_LU));
        check("lu1_first", 32'(obs), 32'(O_LU));
        idle();
        check("lu2_hold", 32'(obs2), 32'(O_LU));
        check("lu1_done", 32'(obs), 32'(O_RUN));
        idle();
        check("lu2_done", 32'(obs2), 32'(O_RUN));
        check("lu2_stall_count", stall_count2, 32'd2);
        check("lu1_stall_count", stall_count, 32'd1);

        // LU_HOLD interrupted by a dmem wait resumes its remaining bubble.
        hazard_step();
        dwait_step();
        check("luhold_dwait_freeze", 32'(obs2), 32'(O_FRZ));
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("luhold_resume", 32'(obs2), 32'(O_LU));
        idle();
        check("luhold_resume_done", 32'(obs2), 32'(O_RUN));
        check("luhold_stall_count", stall_count2, 32'd5);

        // Redirect cancels a pending LU_HOLD bubble.
        hazard_step();
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("luhold_redirect", 32'(obs2), 32'(O_RED));
        idle();
        check("luhold_cancelled", 32'(obs2), 32'(O_RUN));
        check("luhold_flush_count", flush_count2, 32'd1);

        // Saturation of both perf counters from preloaded values.
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        dut.stall_cnt <= 32'hFFFF_FFFE;
        dut.flush_cnt <= 32'hFFFF_FFFF;
        #1;
        check("sat_preload", stall_count, 32'hFFFF_FFFE);
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("sat_reach", stall_count, 32'hFFFF_FFFF);
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("sat_stall_hold", stall_count, 32'hFFFF_FFFF);
        idle();
        check("sat_stall_hold2", stall_count, 32'hFFFF_FFFF);
        check("sat_flush_hold", flush_count, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
